// File: rtl/arith_pkg.sv
// ============================================================================
// Module      : arith_pkg
// Description : Shared types and constants for the serial arithmetic blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arith_pkg;

    // Default operand/result width of the serial subtractor
    localparam int SUB_W = 6;

    // Serial subtractor control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    // Bit-counter width for a given operand width (never narrower than one bit)
    function automatic int sub_cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    // Two's-complement overflow of a - b from the operand and result sign bits
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                     input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sixbit_serial_sub_if.sv
// ============================================================================
// Module      : sixbit_serial_sub_if
// Description : Operand/result valid-ready bundle for the serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sixbit_serial_sub_if
    import arith_pkg::*;
#(
    parameter int WIDTH = SUB_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
    logic             zero;

    // Producer/consumer side of the subtractor
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, ovf, zero
    );

    // Subtractor side
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, ovf, zero
    );
endinterface

`default_nettype wire

// File: rtl/full_subtractor.sv
// ============================================================================
// Module      : full_subtractor
// Description : One-bit full subtractor cell (a - b - bin).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor (
    input  wire logic a,
    input  wire logic b,
    input  wire logic bin,
    output logic      d,
    output logic      bout
);
    // Difference bit and borrow-out of a single bit position
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

`default_nettype wire

// File: rtl/sixbit_serial_sub.sv
// ============================================================================
// Module      : sixbit_serial_sub
// Description : Bit-serial LSB-first subtractor with borrow/overflow/zero flags
//               and valid/ready handshakes on operands and result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sixbit_serial_sub
    import arith_pkg::*;
#(
    parameter int WIDTH = SUB_W
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    sixbit_serial_sub_if.slave bus
);
    localparam int                 C_CNT_W    = sub_cnt_w(WIDTH);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(WIDTH - 1);

    sub_state_t          r_state;
    logic [C_CNT_W-1:0]  r_cnt;
    logic                r_br;
    logic [WIDTH-1:0]    r_a_sh;
    logic [WIDTH-1:0]    r_b_sh;
    // Holds the upper WIDTH-1 result bits; the final bit arrives on the last cycle
    logic [WIDTH-2:0]    r_diff_sh;
    logic                r_a_msb;
    logic                r_b_msb;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [WIDTH-1:0]    r_diff;
    logic                r_borrow;
    logic                r_ovf;
    logic                r_zero;

    logic                w_d;
    logic                w_bout;
    logic [WIDTH-1:0]    w_diff_full;

    // The single subtractor cell working on the current LSBs
    full_subtractor u_fs (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_bout)
    );

    // Result with this cycle's difference bit inserted at the MSB
    assign w_diff_full = {w_d, r_diff_sh};

    // Control FSM, shift datapath, borrow flop and registered result flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_br        <= 1'b0;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_diff_sh   <= '0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_diff      <= '0;
            r_borrow    <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a_sh     <= bus.a;
                        r_b_sh     <= bus.b;
                        r_a_msb    <= bus.a[WIDTH-1];
                        r_b_msb    <= bus.b[WIDTH-1];
                        r_br       <= 1'b0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_br      <= w_bout;
                    r_diff_sh <= w_diff_full[WIDTH-1:1];
                    r_a_sh    <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh    <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_cnt     <= r_cnt + 1'b1;
                    if (r_cnt == C_CNT_LAST) begin
                        r_diff      <= w_diff_full;
                        r_borrow    <= w_bout;
                        r_ovf       <= sub_ovf(r_a_msb, r_b_msb, w_d);
                        r_zero      <= ~|w_diff_full;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.diff      = r_diff;
    assign bus.borrow    = r_borrow;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;
endmodule

`default_nettype wire

// File: doc/sixbit_serial_sub.md
# sixbit_serial_sub

Bit-serial 6-bit subtractor, LSB first. It computes `a - b` using one full-subtractor cell, a borrow flop and shift registers, and reports difference, unsigned borrow, signed overflow and zero. It is the arithmetic inverse of the team's 6-bit ripple adder and serves area-constrained datapaths. Operands and results are exchanged over valid/ready handshakes.

## Interface
Parameters:
- `WIDTH`, 6, operand and result width; must be ≥2.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset; release is synchronised externally.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block can accept operands.
- `a` in WIDTH: minuend.
- `b` in WIDTH: subtrahend.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `diff` out WIDTH: `(a - b) mod 2^WIDTH`.
- `borrow` out 1: `a < b` unsigned.
- `ovf` out 1: signed two's-complement overflow.
- `zero` out 1: `diff == 0`.

## Operation
- FSM states are IDLE, SHIFT and DONE. Reset state is IDLE.
- **IDLE**
  - `in_ready=1`.
  - When `in_valid & in_ready`: latch `a` into `a_sh` and `b` into `b_sh`; clear the borrow flop; set `cnt=0`; set `a_msb=a[WIDTH-1]` and `b_msb=b[WIDTH-1]`; go to SHIFT.
- **SHIFT** (`in_ready=0`)
  - Each cycle: `d = a_sh[0] ^ b_sh[0] ^ br`.
  - Borrow update: `br' = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br)`.
  - `d` shifts into `diff_sh` from the MSB side. `a_sh` and `b_sh` shift right. `cnt++`.
  - After the cycle with `cnt==WIDTH-1`, go to DONE.
- **DONE**
  - `out_valid=1`. `diff`, `borrow`, `ovf` and `zero` are registered and stable.
  - `borrow` = final `br`.
  - `ovf = (a_msb != b_msb) & (diff[WIDTH-1] != a_msb)`.
  - `zero = ~|diff`.
  - When `out_ready`, go to IDLE.
- Outputs hold their last values while not in DONE. Consumers qualify them with `out_valid`.
- Inputs `a` and `b` are ignored outside the IDLE handshake. Changing them mid-operation has no effect.
- There is no accept-while-DONE path. At most one operation is in flight.

## Timing
- All outputs reset to 0, except `in_ready`, which resets to 1 (state IDLE).
- Handshake at edge T0 in IDLE. SHIFT occupies edges T0+1 … T0+WIDTH. `out_valid` goes high after edge T0+WIDTH.
- Latency from accept to `out_valid` is WIDTH cycles (6).
- With `out_ready` held high, the result transfers at edge T0+WIDTH+1 and `in_ready` rises after it.
- Minimum issue interval is WIDTH+2 = 8 cycles.
- Back-pressure: `out_valid` and all result outputs hold unchanged for any number of cycles with `out_ready=0`.
- `out_ready` asserted outside DONE has no effect. `in_valid` outside IDLE is not accepted, and the source must hold it.
- Reset asserted in any state immediately returns to IDLE and clears `cnt`, `br`, the shift registers and all outputs. The in-flight result is discarded with no partial `out_valid`.
- Wrap-around: `diff` is modulo 2^WIDTH. No saturation.

## Structure
- Shared package `arith_pkg`:
  - FSM state enum `sub_state_t` (IDLE, SHIFT, DONE).
  - Constant `SUB_W = 6` used as the `WIDTH` default.
  - Counter width `$clog2(WIDTH)`.
- One sub-module, `full_subtractor` (inputs `a`, `b`, `bin`; outputs `d`, `bout`), is purely combinational and instantiated once in SHIFT datapath.
- The top level contains the FSM, counter, shift registers, borrow flop and flag logic.

## Test plan
- `a=13`, `b=5` → after 6 cycles: `diff=8`, `borrow=0`, `ovf=0`, `zero=0`; `in_ready` is low for exactly 7 cycles with `out_ready=1`.
- `a=5`, `b=13` → `diff=0x38`, `borrow=1`, `ovf=0`; `a=0`, `b=1` → `diff=0x3F`, `borrow=1`, `ovf=0`; `a=b=0x2A` → `diff=0`, `zero=1`.
- Signed overflow:
  - `a=0x1F`, `b=0x20` → `diff=0x3F`, `ovf=1`, `borrow=1`.
  - `a=0x20`, `b=0x01` → `diff=0x1F`, `ovf=1`, `borrow=0`.
- Back-pressure: hold `out_ready=0` for 4 cycles in DONE → outputs stable and `in_valid` not accepted; release → one transfer, then IDLE.
- Reset mid-operation: assert `rst_n=0` at cycle 3 of SHIFT → all outputs 0 and `in_ready=1` without waiting for a clock edge. Then a new operation `a=7`, `b=2` returns `diff=5`.
- Random: 1000 back-to-back operations with random `out_ready` stalls, compared against the reference model `(a-b)&0x3F` plus the flags.
